// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared state encoding, default geometry and depth helper for fifo_ctrl.
package fifo_ctrl_pkg;
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
    localparam int ADDR_WIDTH_DEF = 2;
    localparam int AF_THRESH_DEF  = 3;
    localparam int AE_THRESH_DEF  = 1;
    function automatic int depth(input int aw);
        return 2 ** aw;
    endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping address pointer; clr beats inc, wrap comes from natural overflow.
module fifo_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: push/pop sequencer and occupancy flags for a reg_file-backed FIFO.
// Sticky overflow/underflow registers exist only when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl import fifo_ctrl_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_THRESH  = AF_THRESH_DEF,
    parameter int AE_THRESH  = AE_THRESH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = depth(ADDR_WIDTH);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_chk
        $error("fifo_ctrl: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_chk
        $error("fifo_ctrl: AE_THRESH out of range 0..DEPTH-1");
    end

    state_t state;
    logic do_rd, do_wr;
    logic [CW-1:0] count_next;

    // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
    assign do_rd = rd & ~empty & ~flush;
    assign do_wr = wr & (~full | do_rd) & ~flush;
    assign wr_en = do_wr;
    assign count_next = flush ? '0 : count + CW'(do_wr) - CW'(do_rd);
    assign full = state == FULL;
    assign empty = state == EMPTY;

    fifo_ptr #(.W(ADDR_WIDTH)) u_wptr (.clk, .reset, .inc(do_wr), .clr(flush), .ptr(w_addr));
    fifo_ptr #(.W(ADDR_WIDTH)) u_rptr (.clk, .reset, .inc(do_rd), .clr(flush), .ptr(r_addr));

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= EMPTY;
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            state        <= count_next == '0 ? EMPTY : count_next == DEPTH_C ? FULL : PARTIAL;
            count        <= count_next;
            almost_full  <= count_next >= AF_C;
            almost_empty <= count_next <= AE_C;
        end

`ifdef FIFO_CTRL_ERR_EN
    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr & full & ~do_rd & ~flush) | (overflow & ~clr_err);
            underflow <= (rd & empty & ~flush) | (underflow & ~clr_err);
        end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed checks of fifo_ctrl; error-flag expectations follow FIFO_CTRL_ERR_EN.
module tb_fifo_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic wr_en, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [1:0] w_addr, r_addr;
    logic [2:0] count;
    int tests = 0, fails = 0;
`ifdef FIFO_CTRL_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    fifo_ctrl #(.ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr), .count(count), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests at the falling edge, check wr_en, then settle past the rising edge.
    task automatic step(input logic w, input logic r, input logic f, input logic c, input logic exp_wr_en);
        @(negedge clk);
        wr = w; rd = r; flush = f; clr_err = c;
        #1 chk("wr_en", wr_en, exp_wr_en);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_waddr", w_addr, 0);
        chk("rst_raddr", r_addr, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);

        step(1, 0, 0, 0, 1);
        chk("p1_count", count, 1); chk("p1_empty", empty, 0); chk("p1_ae", almost_empty, 1);
        step(1, 0, 0, 0, 1);
        chk("p2_count", count, 2); chk("p2_ae", almost_empty, 0); chk("p2_af", almost_full, 0);
        step(1, 0, 0, 0, 1);
        chk("p3_count", count, 3); chk("p3_af", almost_full, 1); chk("p3_full", full, 0);
        step(1, 0, 0, 0, 1);
        chk("p4_count", count, 4); chk("p4_full", full, 1); chk("p4_waddr", w_addr, 0);
        step(1, 0, 0, 0, 0);
        chk("p5_ovf", overflow, ERR); chk("p5_count", count, 4); chk("p5_waddr", w_addr, 0);

        for (int i = 1; i <= 3; i++) begin
            step(1, 1, 0, 0, 1);
            chk("wr_rd_full_count", count, 4);
            chk("wr_rd_full_full", full, 1);
            chk("wr_rd_full_waddr", w_addr, i);
            chk("wr_rd_full_raddr", r_addr, i);
        end
        chk("ovf_sticky", overflow, ERR);
        step(0, 0, 0, 1, 0);
        chk("ovf_clr", overflow, 0);

        for (int i = 3; i >= 0; i--) begin
            step(0, 1, 0, 0, 0);
            chk("drain_count", count, i);
        end
        chk("drain_empty", empty, 1); chk("drain_raddr", r_addr, 3); chk("drain_udf", underflow, 0);
        step(0, 0, 1, 0, 0);
        chk("fl_waddr", w_addr, 0); chk("fl_raddr", r_addr, 0);

        step(1, 1, 0, 0, 1);
        chk("e_wr_rd_count", count, 1); chk("e_wr_rd_raddr", r_addr, 0);
        chk("e_wr_rd_waddr", w_addr, 1); chk("e_wr_rd_udf", underflow, ERR);
        step(0, 0, 0, 1, 0);
        chk("udf_clr", underflow, 0);
        step(0, 1, 0, 0, 0);
        chk("pop_count", count, 0); chk("pop_raddr", r_addr, 1);
        step(0, 1, 0, 1, 0);
        chk("set_beats_clr", underflow, ERR);
        step(0, 0, 0, 1, 0);
        chk("udf_clr2", underflow, 0);

        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("ovf2", overflow, ERR);
        step(0, 1, 0, 0, 0);
        chk("pre_flush_count", count, 3);
        step(1, 0, 1, 0, 0);
        chk("flush_count", count, 0); chk("flush_empty", empty, 1); chk("flush_ae", almost_empty, 1);
        chk("flush_af", almost_full, 0); chk("flush_waddr", w_addr, 0); chk("flush_raddr", r_addr, 0);
        chk("flush_keeps_ovf", overflow, ERR);
        step(0, 1, 1, 0, 0);
        chk("flush_rd_no_udf", underflow, 0);

        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("burst_count", count, 2);
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", count, 0); chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ae", almost_empty, 1); chk("mid_rst_af", almost_full, 0);
        chk("mid_rst_waddr", w_addr, 0); chk("mid_rst_ovf", overflow, 0);
        reset = 1'b0;
        wr = 1'b0;
        step(1, 0, 0, 0, 1);
        chk("post_rst_count", count, 1); chk("post_rst_waddr", w_addr, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
